// File: rtl/router_switch_alloc_4port.sv
// Wormhole switch allocator for the 4-port mesh router: per-output round-robin
// arbitration, head-to-tail locking, crossbar select and flit handshakes.
`ifndef EMPTY
`define EMPTY          3'd0
`endif
`ifndef OUT_LOCAL_PORT
`define OUT_LOCAL_PORT 3'd1
`endif
`ifndef OUT_X1_PORT
`define OUT_X1_PORT    3'd2
`endif
`ifndef OUT_X2_PORT
`define OUT_X2_PORT    3'd3
`endif
`ifndef OUT_Y1_PORT
`define OUT_Y1_PORT    3'd4
`endif

module router_switch_alloc_4port (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  in_valid,
    input  logic [11:0] in_port,
    input  logic [3:0]  in_tail,
    input  logic [3:0]  out_ready,
    output logic [3:0]  in_ready,
    output logic [3:0]  out_valid,
    output logic [7:0]  out_sel,
    output logic [3:0]  out_busy
);

    logic [3:0] locked;
    logic [1:0] owner [4];
    logic [1:0] rr    [4];
    logic [3:0] is_owner;
    logic [3:0] req   [4];
    logic [2:0] grant [4];

    // Returns {hit, output index}; EMPTY and undefined codes never hit.
    function automatic logic [2:0] decode_port(input logic [2:0] code);
        case (code)
            `OUT_LOCAL_PORT: return 3'b100;
            `OUT_X1_PORT:    return 3'b101;
            `OUT_X2_PORT:    return 3'b110;
            `OUT_Y1_PORT:    return 3'b111;
            default:         return 3'b000;
        endcase
    endfunction

    // Returns {found, winner}; the requester closest to ptr (inclusive) wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (r[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    always_comb begin
        is_owner = '0;
        for (int o = 0; o < 4; o++)
            if (locked[o]) is_owner[owner[o]] = 1'b1;
    end

    always_comb begin
        logic [2:0] dec;
        dec = '0;
        for (int o = 0; o < 4; o++) begin
            req[o] = '0;
            for (int i = 0; i < 4; i++) begin
                dec = decode_port(in_port[3*i +: 3]);
                if (in_valid[i] && !is_owner[i] && dec[2] && dec[1:0] == 2'(o))
                    req[o][i] = 1'b1;
            end
            grant[o] = rr_pick(req[o], rr[o]);
        end
    end

    // Handshakes depend only on lock state and valid/ready, never on in_port.
    always_comb begin
        in_ready  = '0;
        out_valid = '0;
        out_sel   = '0;
        out_busy  = '0;
        for (int o = 0; o < 4; o++) begin
            if (locked[o]) begin
                out_valid[o]       = in_valid[owner[o]];
                out_busy[o]        = 1'b1;
                out_sel[2*o +: 2]  = owner[o];
                in_ready[owner[o]] = out_ready[o];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked <= '0;
            for (int o = 0; o < 4; o++) begin
                owner[o] <= '0;
                rr[o]    <= '0;
            end
        end else begin
            for (int o = 0; o < 4; o++) begin
                if (locked[o]) begin
                    if (in_valid[owner[o]] && out_ready[o] && in_tail[owner[o]])
                        locked[o] <= 1'b0;
                end else if (grant[o][2]) begin
                    locked[o] <= 1'b1;
                    owner[o]  <= grant[o][1:0];
                    rr[o]     <= grant[o][1:0] + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_switch_alloc_4port.sv
// Bench for router_switch_alloc_4port: directed scenarios plus random traffic,
// all checked every cycle against a per-output ownership model.
`ifndef EMPTY
`define EMPTY          3'd0
`endif
`ifndef OUT_LOCAL_PORT
`define OUT_LOCAL_PORT 3'd1
`endif
`ifndef OUT_X1_PORT
`define OUT_X1_PORT    3'd2
`endif
`ifndef OUT_X2_PORT
`define OUT_X2_PORT    3'd3
`endif
`ifndef OUT_Y1_PORT
`define OUT_Y1_PORT    3'd4
`endif

module tb_router_switch_alloc_4port;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid, in_tail, out_ready;
    logic [11:0] in_port;
    logic [3:0]  in_ready, out_valid, out_busy;
    logic [7:0]  out_sel;

    always #5 clk = ~clk;

    router_switch_alloc_4port dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_port(in_port),
        .in_tail(in_tail), .out_ready(out_ready), .in_ready(in_ready),
        .out_valid(out_valid), .out_sel(out_sel), .out_busy(out_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: m_own[o] = owning input or -1 when the output is free.
    int  m_own [4];
    int  m_rr  [4];
    bit  m_known = 0;
    logic [3:0] e_ir, e_ov, e_busy;
    logic [7:0] e_sel;

    int         pk_left [4];
    logic [2:0] pk_code [4];
    logic [3:0] hold_mask = 4'b0;
    bit         rand_mode = 0;
    int         vld_pct = 100;

    logic [2:0] codes [4];
    logic [2:0] junk  [4];

    function automatic int code_out(input logic [2:0] c);
        if (c == `OUT_LOCAL_PORT) return 0;
        if (c == `OUT_X1_PORT)    return 1;
        if (c == `OUT_X2_PORT)    return 2;
        if (c == `OUT_Y1_PORT)    return 3;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_pkt(input int i, input logic [2:0] code, input int n);
        pk_code[i] = code;
        pk_left[i] = n;
    endtask

    task automatic drive();
        int r;
        for (int i = 0; i < 4; i++) begin
            if (rand_mode && pk_left[i] == 0) begin
                r = $urandom_range(0, 99);
                if (r < 25) start_pkt(i, codes[$urandom_range(0, 3)], $urandom_range(1, 4));
            end
            if (pk_left[i] > 0) begin
                in_valid[i]        = !hold_mask[i] && ($urandom_range(0, 99) < vld_pct);
                in_port[3*i +: 3]  = pk_code[i];
                in_tail[i]         = (pk_left[i] == 1);
            end else if (rand_mode && $urandom_range(0, 99) < 10) begin
                in_valid[i]        = 1'b1;
                in_port[3*i +: 3]  = junk[$urandom_range(0, 3)];
                in_tail[i]         = 1'($urandom_range(0, 1));
            end else begin
                in_valid[i]        = 1'b0;
                in_port[3*i +: 3]  = 3'($urandom_range(0, 7));
                in_tail[i]         = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic step();
        int  n_own [4];
        int  n_rr  [4];
        bit  busy_in [4];
        bit  found;
        int  c, k;
        drive();
        #2;
        e_ir = '0; e_ov = '0; e_busy = '0; e_sel = '0;
        for (int o = 0; o < 4; o++) begin
            if (m_own[o] >= 0) begin
                e_busy[o]          = 1'b1;
                e_sel[2*o +: 2]    = 2'(m_own[o]);
                e_ov[o]            = in_valid[m_own[o]];
                if (out_ready[o]) e_ir[m_own[o]] = 1'b1;
            end
        end
        if (m_known) begin
            chk("in_ready",  {4'b0, in_ready},  {4'b0, e_ir});
            chk("out_valid", {4'b0, out_valid}, {4'b0, e_ov});
            chk("out_sel",   out_sel,           e_sel);
            chk("out_busy",  {4'b0, out_busy},  {4'b0, e_busy});
        end
        for (int i = 0; i < 4; i++) begin
            busy_in[i] = 0;
            for (int o = 0; o < 4; o++) if (m_own[o] == i) busy_in[i] = 1;
        end
        for (int o = 0; o < 4; o++) begin
            n_own[o] = m_own[o];
            n_rr[o]  = m_rr[o];
            if (m_own[o] >= 0) begin
                k = m_own[o];
                if (in_valid[k] && out_ready[o] && in_tail[k]) n_own[o] = -1;
            end else begin
                found = 0;
                for (int j = 0; j < 4; j++) begin
                    c = (m_rr[o] + j) % 4;
                    if (!found && in_valid[c] && !busy_in[c] &&
                        code_out(in_port[3*c +: 3]) == o) begin
                        found    = 1;
                        n_own[o] = c;
                        n_rr[o]  = (c + 1) % 4;
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++)
            if (in_valid[i] && e_ir[i] && pk_left[i] > 0) pk_left[i]--;
        for (int o = 0; o < 4; o++) begin
            m_own[o] = rst ? -1 : n_own[o];
            m_rr[o]  = rst ? 0  : n_rr[o];
        end
        if (rst) m_known = 1;
        @(posedge clk);
        #1;
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < 4; i++) if (pk_left[i] != 0) return 0;
        for (int o = 0; o < 4; o++) if (m_own[o] >= 0) return 0;
        return 1;
    endfunction

    task automatic drain(input string tag);
        bit done;
        done = 0;
        for (int n = 0; n < 80 && !done; n++) begin
            if (all_idle()) done = 1;
            else step();
        end
        chk(tag, {7'b0, done}, 8'd1);
    endtask

    initial begin
        int ir_cnt, ng;
        bit prev_b, restarted;
        logic [1:0] exp_order [4];
        codes[0] = `OUT_LOCAL_PORT; codes[1] = `OUT_X1_PORT;
        codes[2] = `OUT_X2_PORT;    codes[3] = `OUT_Y1_PORT;
        junk[0] = `EMPTY; junk[1] = 3'd5; junk[2] = 3'd6; junk[3] = 3'd7;
        exp_order[0] = 2'd1; exp_order[1] = 2'd2; exp_order[2] = 2'd3; exp_order[3] = 2'd1;
        for (int i = 0; i < 4; i++) begin
            m_own[i] = -1; m_rr[i] = 0; pk_left[i] = 0; pk_code[i] = '0;
        end
        rst = 1'b1; in_valid = '0; in_port = '0; in_tail = '0; out_ready = 4'hF;
        @(posedge clk); #1;

        // Reset with random activity on the inputs
        rand_mode = 1; vld_pct = 80;
        step(); step();
        rand_mode = 0; vld_pct = 100; rst = 1'b0;
        for (int i = 0; i < 4; i++) pk_left[i] = 0;
        step();
        chk("rst_busy", {4'b0, out_busy}, 8'h00);

        // Single 3-flit packet LOCAL -> X2
        start_pkt(0, `OUT_X2_PORT, 3);
        step();
        chk("single_busy", {7'b0, out_busy[2]}, 8'd1);
        chk("single_sel",  {6'b0, out_sel[5:4]}, 8'd0);
        ir_cnt = 0;
        for (int n = 0; n < 10 && pk_left[0] != 0; n++) begin
            step();
            if (e_ir[0]) ir_cnt++;
        end
        chk("single_ready_cycles", 8'(ir_cnt), 8'd3);
        chk("single_release", {7'b0, out_busy[2]}, 8'd0);

        // Contention on LOCAL output with rr wrap
        start_pkt(1, `OUT_LOCAL_PORT, 2);
        start_pkt(2, `OUT_LOCAL_PORT, 2);
        start_pkt(3, `OUT_LOCAL_PORT, 2);
        ng = 0; prev_b = 0; restarted = 0;
        for (int n = 0; n < 40 && !(ng == 4 && all_idle()); n++) begin
            step();
            if (out_busy[0] && !prev_b && ng < 4) begin
                chk("grant_order", {6'b0, out_sel[1:0]}, {6'b0, exp_order[ng]});
                ng++;
            end
            prev_b = out_busy[0];
            if (pk_left[1] == 0 && !restarted) begin
                start_pkt(1, `OUT_LOCAL_PORT, 2);
                restarted = 1;
            end
        end
        chk("grant_count", 8'(ng), 8'd4);
        drain("contention_drain");

        // Back-pressure mid-packet on Y1
        start_pkt(1, `OUT_Y1_PORT, 6);
        step(); step();
        out_ready[3] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("bp_ready", {7'b0, in_ready[1]}, 8'd0);
            chk("bp_busy",  {7'b0, out_busy[3]}, 8'd1);
        end
        chk("bp_left", 8'(pk_left[1]), 8'd5);
        out_ready[3] = 1'b1;
        drain("bp_drain");

        // Parallel allocation and an in_valid gap
        start_pkt(0, `OUT_X1_PORT, 3);
        start_pkt(3, `OUT_X2_PORT, 3);
        step();
        chk("par_busy", {4'b0, out_busy}, 8'h06);
        hold_mask = 4'b0001;
        step(); step();
        chk("gap_valid", {7'b0, out_valid[1]}, 8'd0);
        chk("gap_busy",  {7'b0, out_busy[1]},  8'd1);
        hold_mask = 4'b0000;
        drain("par_drain");

        // Reset during flit 2 of 4
        start_pkt(2, `OUT_LOCAL_PORT, 4);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) pk_left[i] = 0;
        chk("mrst_ready", {4'b0, in_ready},  8'h00);
        chk("mrst_valid", {4'b0, out_valid}, 8'h00);
        chk("mrst_sel",   out_sel,           8'h00);
        chk("mrst_busy",  {4'b0, out_busy},  8'h00);
        start_pkt(1, `OUT_LOCAL_PORT, 1);
        start_pkt(3, `OUT_LOCAL_PORT, 1);
        step();
        chk("mrst_grant", {6'b0, out_sel[1:0]}, 8'd1);
        drain("mrst_drain");

        // Random traffic
        rand_mode = 1; vld_pct = 80;
        for (int n = 0; n < 3000; n++) begin
            out_ready = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 199) == 0);
            if (rst) for (int i = 0; i < 4; i++) pk_left[i] = 0;
            step();
            if (rst) for (int i = 0; i < 4; i++) pk_left[i] = 0;
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
